// File: rtl/clk_freq_gen.sv
// Four free-running clock dividers plus a debounced push-button that steps the
// 2-bit speed selector feeding the downstream clock mux.
module clk_freq_gen #(
    parameter int DIV0       = 25_000_000,
    parameter int DIV1       = 12_500_000,
    parameter int DIV2       = 2_500_000,
    parameter int DIV3       = 250_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    output logic       clk0,
    output logic       clk1,
    output logic       clk2,
    output logic       clk3,
    output logic [1:0] sel,
    output logic       sel_changed
);

    function automatic int div_of(input int idx);
        case (idx)
            0:       return DIV0;
            1:       return DIV1;
            2:       return DIV2;
            default: return DIV3;
        endcase
    endfunction

    logic [3:0] clk_div;

    // Each divider owns its own counter width so small ratios stay small.
    for (genvar i = 0; i < 4; i++) begin : g_div
        localparam int           DIV  = div_of(i);
        localparam int           W    = $clog2(DIV) + 1;
        localparam logic [W-1:0] LAST = W'(DIV - 1);

        logic [W-1:0] cnt_q;
        logic [W-1:0] cnt_d;
        logic         clk_q;
        logic         clk_d;

        always_comb begin
            cnt_d = cnt_q + W'(1);
            clk_d = clk_q;
            if (cnt_q == LAST) begin
                cnt_d = '0;
                clk_d = ~clk_q;
            end
        end

        // NOTE: state flops use non-blocking assignments so every register
        // samples the pre-edge value of its neighbours, independent of block order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                clk_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                clk_q <= clk_d;
            end
        end

        assign clk_div[i] = clk_q;
    end

    assign clk0 = clk_div[0];
    assign clk1 = clk_div[1];
    assign clk2 = clk_div[2];
    assign clk3 = clk_div[3];

    localparam int            DW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic [1:0]    sel_q;
    logic [1:0]    sel_d;
    logic          sel_changed_q;
    logic          sel_changed_d;

    // The selector steps on the same edge that the debounced level rises.
    always_comb begin
        stable_d      = stable_q;
        dcnt_d        = '0;
        sel_d         = sel_q;
        sel_changed_d = 1'b0;
        if (s2_q != stable_q) begin
            if (dcnt_q == DEB_LAST) begin
                stable_d = s2_q;
                if (s2_q) begin
                    sel_d         = sel_q + 2'd1;
                    sel_changed_d = 1'b1;
                end
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            stable_q      <= 1'b0;
            dcnt_q        <= '0;
            sel_q         <= 2'b00;
            sel_changed_q <= 1'b0;
        end else begin
            s1_q          <= btn_next;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            dcnt_q        <= dcnt_d;
            sel_q         <= sel_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    assign sel         = sel_q;
    assign sel_changed = sel_changed_q;

endmodule
